// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Purpose: request/response bundle between two requesters and the ALU
//          share arbiter. Index [i] of every vector belongs to requester i.
// Signals:
//   req_valid/req_ready  per-requester op handshake
//   req_in1/req_in2      operands, WIDTH bits each
//   req_func             ALU function code, FUNC_W bits
//   req_lock             hold ownership after this op (lock build only)
//   rsp_valid/rsp_ready  per-requester result handshake
//   rsp_data             registered result, WIDTH bits
// Modports:
//   master  requester side (drives requests, consumes results)
//   slave   arbiter side
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FUNC_W = 4
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][WIDTH-1:0]  req_in1;
  logic [1:0][WIDTH-1:0]  req_in2;
  logic [1:0][FUNC_W-1:0] req_func;
  logic [1:0]             req_lock;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready;
  logic [1:0][WIDTH-1:0]  rsp_data;

  modport master (
    output req_valid, req_in1, req_in2, req_func, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_in1, req_in2, req_func, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Purpose: shares one external combinational ALU between two requesters with
//          round-robin arbitration, a valid/ready handshake per requester and
//          a registered result per requester (latency 1).
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   bus          alu_share_arbiter_if.slave request/response bundle
//   alu_in1/2    operands to the ALU (zero when no grant)
//   alu_func     function code to the ALU (zero when no grant, never decoded)
//   alu_out      ALU result, captured into the granted requester's rsp_data
//   gnt_id       requester granted this cycle (meaningful when alu_busy)
//   alu_busy     a grant is issued this cycle
// Configuration:
//   ALU_ARB_LOCK_EN  when defined, req_lock lets a requester keep the ALU
//                    for back-to-back ops; otherwise pure round-robin.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FUNC_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [WIDTH-1:0]    alu_in1,
  output logic [WIDTH-1:0]    alu_in2,
  output logic [FUNC_W-1:0]   alu_func,
  input  logic [WIDTH-1:0]    alu_out,
  output logic                gnt_id,
  output logic                alu_busy
);

  localparam int unsigned NREQ = 2;

  logic [NREQ-1:0] lock_mask_c;
  logic [NREQ-1:0] eligible_c;
  logic [NREQ-1:0] grant_c;
  logic            last_gnt;

`ifdef ALU_ARB_LOCK_EN
  // Lock ownership register: which requester currently holds the ALU.
  localparam logic [1:0] LOCK_NONE = 2'b00;
  localparam logic [1:0] LOCK_REQ0 = 2'b01;
  localparam logic [1:0] LOCK_REQ1 = 2'b10;

  logic [1:0] lock_q;
  logic [1:0] lock_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= LOCK_NONE;
    end else begin
      lock_q <= lock_d;
    end
  end

  // The lock only masks the other requester while the owner is presenting;
  // an owner that drops req_valid gives the ALU up in that same cycle.
  always_comb begin
    lock_mask_c = 2'b11;
    if (lock_q == LOCK_REQ0 && bus.req_valid[0]) begin
      lock_mask_c = 2'b01;
    end else if (lock_q == LOCK_REQ1 && bus.req_valid[1]) begin
      lock_mask_c = 2'b10;
    end
  end

  // Next lock owner: any transfer re-decides from its req_lock; otherwise
  // release when the owner is not presenting.
  always_comb begin
    lock_d = lock_q;
    if (alu_busy) begin
      if (bus.req_lock[gnt_id]) begin
        lock_d = gnt_id ? LOCK_REQ1 : LOCK_REQ0;
      end else begin
        lock_d = LOCK_NONE;
      end
    end else begin
      case (lock_q)
        LOCK_REQ0: if (!bus.req_valid[0]) lock_d = LOCK_NONE;
        LOCK_REQ1: if (!bus.req_valid[1]) lock_d = LOCK_NONE;
        default:   lock_d = LOCK_NONE;
      endcase
    end
  end
`else
  // No lock state: req_lock is deliberately ignored.
  logic unused_req_lock;
  assign unused_req_lock = ^bus.req_lock;
  assign lock_mask_c     = 2'b11;
`endif

  // A requester may be served only if its result slot is free or draining.
  assign eligible_c = bus.req_valid & (~bus.rsp_valid | bus.rsp_ready) & lock_mask_c;

  // Round-robin grant; held off entirely while reset is asserted so the
  // ALU operands read zero immediately.
  always_comb begin
    grant_c = '0;
    if (rst_n) begin
      case (eligible_c)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = last_gnt ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

  assign bus.req_ready = grant_c;
  assign gnt_id        = grant_c[1];
  assign alu_busy      = |grant_c;

  // Operand mux towards the ALU; zero when idle.
  always_comb begin
    alu_in1  = '0;
    alu_in2  = '0;
    alu_func = '0;
    if (grant_c[0]) begin
      alu_in1  = bus.req_in1[0];
      alu_in2  = bus.req_in2[0];
      alu_func = bus.req_func[0];
    end else if (grant_c[1]) begin
      alu_in1  = bus.req_in1[1];
      alu_in2  = bus.req_in2[1];
      alu_func = bus.req_func[1];
    end
  end

  // Round-robin pointer: remembers the most recent winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (alu_busy) begin
      last_gnt <= gnt_id;
    end
  end

  // Result registers: capture on transfer, clear on drain without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (grant_c[i]) begin
          bus.rsp_valid[i] <= 1'b1;
          bus.rsp_data[i]  <= alu_out;
        end else if (bus.rsp_ready[i]) begin
          bus.rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Invariants: a single grant, and a held result is never overwritten.
  a_onehot_grant: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_c));
  a_no_overwrite0: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rsp_valid[0] && !bus.rsp_ready[0]) |-> !grant_c[0]);
  a_no_overwrite1: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rsp_valid[1] && !bus.rsp_ready[1]) |-> !grant_c[1]);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Purpose: self-checking bench for alu_share_arbiter with an adder ALU stub
//          (alu_out = alu_in1 + alu_in2 + alu_func). Directed table, reset and
//          lock sequences, then random traffic against a behavioural model.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned FUNC_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(WIDTH), .FUNC_W(FUNC_W)) bus ();

  logic [WIDTH-1:0]  alu_in1, alu_in2, alu_out;
  logic [FUNC_W-1:0] alu_func;
  logic              gnt_id, alu_busy;

  assign alu_out = alu_in1 + alu_in2 + WIDTH'(alu_func);

  alu_share_arbiter #(.WIDTH(WIDTH), .FUNC_W(FUNC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_func (alu_func),
    .alu_out  (alu_out),
    .gnt_id   (gnt_id),
    .alu_busy (alu_busy)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_v [2];
  logic [31:0] m_d [2];
  int          m_last;
  int          m_lock;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  rr;
    logic [31:0] in1_0, in2_0;
    logic [3:0]  f0;
    logic [31:0] in1_1, in2_1;
    logic [3:0]  f1;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rv;
    logic [31:0] exp_d0, exp_d1;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    m_d[0] = '0;   m_d[1] = '0;
    m_last = 1;
    m_lock = -1;
  endtask

  // Winner by the arbitration rules; -1 when nobody is served.
  function automatic int model_pick();
    int cand[$];
    bit owner_hold;
    owner_hold = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    if (m_lock >= 0) owner_hold = bus.req_valid[m_lock];
`endif
    if (!rst_n) return -1;
    for (int i = 0; i < 2; i++)
      if (bus.req_valid[i] && (!m_v[i] || bus.rsp_ready[i]) && (!owner_hold || i == m_lock))
        cand.push_back(i);
    if (cand.size() == 0) return -1;
    if (cand.size() == 1) return cand[0];
    return 1 - m_last;
  endfunction

  function automatic logic [31:0] op_sum(input int w);
    return bus.req_in1[w] + bus.req_in2[w] + 32'(bus.req_func[w]);
  endfunction

  task automatic model_edge(input int w, input logic [31:0] sum, input bit lk);
    for (int i = 0; i < 2; i++) begin
      if (i == w) begin
        m_v[i] = 1'b1;
        m_d[i] = sum;
      end else if (bus.rsp_ready[i]) begin
        m_v[i] = 1'b0;
      end
    end
    if (w >= 0) m_last = w;
`ifdef ALU_ARB_LOCK_EN
    if (w >= 0) m_lock = lk ? w : -1;
    else if (m_lock >= 0 && !bus.req_valid[m_lock]) m_lock = -1;
`else
    if (lk) m_lock = -1;
`endif
  endtask

  // Sample at negedge, advance the model at the following posedge.
  task automatic advance(input int w);
    logic [31:0] sum;
    bit lk;
    sum = (w >= 0) ? op_sum(w) : 32'h0;
    lk  = (w >= 0) ? bus.req_lock[w] : 1'b0;
    @(posedge clk);
    model_edge(w, sum, lk);
    #1;
  endtask

  task automatic step_model();
    int w;
    logic [1:0] er;
    @(negedge clk);
    w  = model_pick();
    er = (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10);
    chk("rnd_ready", 32'(bus.req_ready), 32'(er));
    chk("rnd_busy", 32'(alu_busy), 32'(w >= 0));
    if (w >= 0) chk("rnd_gnt_id", 32'(gnt_id), 32'(w));
    chk("rnd_alu_in1", alu_in1, (w < 0) ? 32'h0 : bus.req_in1[w]);
    chk("rnd_alu_in2", alu_in2, (w < 0) ? 32'h0 : bus.req_in2[w]);
    chk("rnd_alu_func", 32'(alu_func), (w < 0) ? 32'h0 : 32'(bus.req_func[w]));
    chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'({m_v[1], m_v[0]}));
    chk("rnd_rsp_data0", bus.rsp_data[0], m_d[0]);
    chk("rnd_rsp_data1", bus.rsp_data[1], m_d[1]);
    advance(w);
  endtask

  task automatic step_table(input int k);
    vec_t v;
    v = tbl[k];
    bus.req_valid  = v.valid;
    bus.rsp_ready  = v.rr;
    bus.req_lock   = 2'b00;
    bus.req_in1[0] = v.in1_0; bus.req_in2[0] = v.in2_0; bus.req_func[0] = v.f0;
    bus.req_in1[1] = v.in1_1; bus.req_in2[1] = v.in2_1; bus.req_func[1] = v.f1;
    @(negedge clk);
    chk($sformatf("tbl%0d_ready", k), 32'(bus.req_ready), 32'(v.exp_ready));
    chk($sformatf("tbl%0d_busy", k), 32'(alu_busy), 32'(|v.exp_ready));
    if (v.exp_ready != 2'b00) chk($sformatf("tbl%0d_gnt_id", k), 32'(gnt_id), 32'(v.exp_ready[1]));
    chk($sformatf("tbl%0d_alu_in1", k), alu_in1,
        v.exp_ready[0] ? v.in1_0 : (v.exp_ready[1] ? v.in1_1 : 32'h0));
    chk($sformatf("tbl%0d_alu_func", k), 32'(alu_func),
        v.exp_ready[0] ? 32'(v.f0) : (v.exp_ready[1] ? 32'(v.f1) : 32'h0));
    chk($sformatf("tbl%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'(v.exp_rv));
    chk($sformatf("tbl%0d_rsp_data0", k), bus.rsp_data[0], v.exp_d0);
    chk($sformatf("tbl%0d_rsp_data1", k), bus.rsp_data[1], v.exp_d1);
    advance(model_pick());
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_data0"}, bus.rsp_data[0], 32'h0);
    chk({tag, "_rsp_data1"}, bus.rsp_data[1], 32'h0);
    chk({tag, "_alu_in1"}, alu_in1, 32'h0);
    chk({tag, "_alu_in2"}, alu_in2, 32'h0);
    chk({tag, "_alu_func"}, 32'(alu_func), 32'h0);
    chk({tag, "_busy"}, 32'(alu_busy), 32'h0);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
  endtask

  // Lock scenario: req0 asks to lock for three ops, then one unlocked op.
`ifdef ALU_ARB_LOCK_EN
  int lock_exp [5] = '{0, 0, 0, 0, 1};
`else
  int lock_exp [5] = '{0, 1, 0, 1, 0};
`endif

  initial begin
    tbl[0]  = '{2'b01, 2'b00, 32'h0A, 32'h02, 4'd1, 32'h0, 32'h0, 4'd0, 2'b01, 2'b00, 32'h0, 32'h0};
    tbl[1]  = '{2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0, 4'd0, 2'b00, 2'b01, 32'h0D, 32'h0};
    tbl[2]  = '{2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0, 4'd0, 2'b00, 2'b01, 32'h0D, 32'h0};
    tbl[3]  = '{2'b00, 2'b01, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0, 4'd0, 2'b00, 2'b01, 32'h0D, 32'h0};
    tbl[4]  = '{2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0, 4'd0, 2'b00, 2'b00, 32'h0D, 32'h0};
    tbl[5]  = '{2'b11, 2'b11, 32'h1, 32'h1, 4'd0, 32'h10, 32'h20, 4'd3, 2'b10, 2'b00, 32'h0D, 32'h0};
    tbl[6]  = '{2'b11, 2'b11, 32'h1, 32'h1, 4'd0, 32'h10, 32'h20, 4'd3, 2'b01, 2'b10, 32'h0D, 32'h33};
    tbl[7]  = '{2'b11, 2'b11, 32'h1, 32'h1, 4'd0, 32'h10, 32'h20, 4'd3, 2'b10, 2'b01, 32'h02, 32'h33};
    tbl[8]  = '{2'b11, 2'b11, 32'h1, 32'h1, 4'd0, 32'h10, 32'h20, 4'd3, 2'b01, 2'b10, 32'h02, 32'h33};
    tbl[9]  = '{2'b11, 2'b00, 32'h1, 32'h1, 4'd0, 32'h5, 32'h6, 4'd0, 2'b10, 2'b01, 32'h02, 32'h33};
    tbl[10] = '{2'b11, 2'b00, 32'h1, 32'h1, 4'd0, 32'h5, 32'h6, 4'd0, 2'b00, 2'b11, 32'h02, 32'h0B};
    tbl[11] = '{2'b11, 2'b01, 32'h100, 32'h23, 4'd2, 32'h5, 32'h6, 4'd0, 2'b01, 2'b11, 32'h02, 32'h0B};
    tbl[12] = '{2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0, 4'd0, 2'b00, 2'b11, 32'h125, 32'h0B};
    tbl[13] = '{2'b10, 2'b10, 32'h0, 32'h0, 4'd0, 32'h7, 32'h8, 4'd1, 2'b10, 2'b11, 32'h125, 32'h0B};
    tbl[14] = '{2'b00, 2'b11, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0, 4'd0, 2'b00, 2'b11, 32'h125, 32'h10};
    tbl[15] = '{2'b00, 2'b00, 32'h0, 32'h0, 4'd0, 32'h0, 32'h0, 4'd0, 2'b00, 2'b00, 32'h125, 32'h10};

    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_lock  = 2'b00;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.req_func  = '0;
    model_reset();

    // Power-on reset
    #12;
    check_reset_vals("por");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int k = 0; k < 16; k++) step_table(k);

    // Lock / round-robin sequence under full contention
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 5; k++) begin
      bus.req_lock = (k < 3) ? 2'b01 : 2'b00;
      bus.req_in1[0] = 32'(k); bus.req_in2[0] = 32'h1; bus.req_func[0] = 4'd0;
      bus.req_in1[1] = 32'h40; bus.req_in2[1] = 32'(k); bus.req_func[1] = 4'd1;
      @(negedge clk);
      chk($sformatf("lock%0d_busy", k), 32'(alu_busy), 32'h1);
      chk($sformatf("lock%0d_gnt_id", k), 32'(gnt_id), 32'(lock_exp[k]));
      advance(model_pick());
    end
    bus.req_lock = 2'b00;

    // Mid-cycle reset with an op in flight and results held
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    #1 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    model_reset();
    bus.req_valid = 2'b00;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        bus.req_valid[i] = ($urandom_range(3, 0) != 0);
        bus.rsp_ready[i] = ($urandom_range(1, 0) != 0);
        bus.req_lock[i]  = ($urandom_range(2, 0) == 0);
        bus.req_in1[i]   = $urandom;
        bus.req_in2[i]   = $urandom;
        bus.req_func[i]  = 4'($urandom_range(15, 0));
      end
      step_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
